pipe_seq_ctrl: RTL
==================

PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

Interface
REQ-001 SHALL have these ports (name direction width meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  host pulse: clear PC to 0, run.
- halt_req  in  1  host request to halt.
- step_req  in  1  host request to execute one instruction while halted.
- idex_mem_read  in  1  ID/EX holds a load.
- idex_rd  in  5  ID/EX destination register.
- ifid_rs1, ifid_rs2  in  5 each  IF/ID source registers.
- ifid_uses_rs2  in  1  IF/ID instruction reads rs2.
- mem_branch  in  2  EX/MEM branch code.
- mem_jump  in  1  EX/MEM holds a jump.
- mem_zero, mem_lt  in  1 each  EX/MEM ALU compare flags.
- pc_write_en  out  1  PC update enable.
- pc_sel  out  1  1 = branch/jump target, 0 = PC+4.
- pc_clear  out  1  force PC to 0.
- ifid_write_en  out  1  IF/ID load enable.
- ifid_flush, idex_flush, exmem_flush  out  1 each  insert a bubble into that register.
- state  out  3  current FSM state.
- cycle_cnt  out  32  active-cycle counter.
REQ-002 SHALL use one clock and an asynchronous, active-high reset, as already decided.

Function
REQ-003 SHALL implement the FSM states IDLE=0, RUN=1, DRAIN=2, HALTED=3, STEP=4; all other encodings return to IDLE.
REQ-004 SHALL drive outputs combinationally from state and current inputs; state, drain counter and cycle_cnt are registered.
REQ-005 SHALL compute taken = mem_jump | (mem_branch==00 & mem_zero) | (mem_branch==01 & ~mem_zero) | (mem_branch==10 & mem_lt); mem_branch==11 means no branch.
REQ-006 SHALL compute load_use = idex_mem_read & idex_rd!=0 & (idex_rd==ifid_rs1 | (ifid_uses_rs2 & idex_rd==ifid_rs2)).
REQ-007 In IDLE SHALL drive pc_write_en=0, all three flushes=1, pc_sel=0, and ifid_write_en=1.
REQ-008 In IDLE or HALTED with start=1, SHALL assert pc_clear for that cycle, clear cycle_cnt, and go to RUN next cycle.
REQ-009 In RUN/STEP SHALL, by default, drive pc_write_en=1, ifid_write_en=1, no flushes, and pc_sel=0.
REQ-010 When taken is 1 (any active state), SHALL drive pc_sel=1, pc_write_en=1, ifid_flush=idex_flush=exmem_flush=1 in the same cycle; taken overrides load_use.
REQ-011 On load_use without taken SHALL drive pc_write_en=0, ifid_write_en=0, and idex_flush=1 for exactly that cycle (1-cycle bubble).
REQ-012 In RUN with halt_req=1 SHALL go to DRAIN with the drain counter loaded to 4; a simultaneous taken is still applied per REQ-010.
REQ-013 In DRAIN SHALL drive pc_write_en=0 and ifid_flush=1 unless taken (REQ-010) or load_use; on load_use, ifid_write_en=0 wins over ifid_flush and the counter holds.
REQ-014 In DRAIN SHALL decrement the counter on each non-stall cycle and go to HALTED when the counter reaches 0 (4 non-stall cycles).
REQ-015 In HALTED SHALL drive the same outputs as IDLE except no flushes on exmem/idex is irrelevant; all flushes=1 and pc_write_en=0.
REQ-016 In HALTED with step_req=1 (and start=0) SHALL go to STEP; start has priority over step_req.
REQ-017 STEP SHALL behave as RUN for one non-stall cycle, then go to DRAIN with the counter loaded to 4; on load_use, STEP is held.
REQ-018 SHALL ignore start in RUN/DRAIN/STEP, halt_req outside RUN, and step_req outside HALTED.
REQ-019 SHALL increment cycle_cnt by 1 each cycle in RUN, STEP, or DRAIN, wrapping modulo 2^32.

Reset
REQ-020 Reset SHALL force state=IDLE, the drain counter to 0, and cycle_cnt to 0, giving outputs per REQ-007 with pc_clear=0.
REQ-021 Reset asserted mid-RUN/DRAIN/STEP SHALL take effect immediately, without waiting for a clock edge.

Structure
REQ-022 A shared package SHALL hold the state encodings, branch codes (BEQ=00, BNE=01, BLT=10, NONE=11), and DRAIN_DEPTH=4.
REQ-023 The load-use compare SHALL be a combinational sub-module pipe_hazard_detect.

Verification
REQ-024 Reset, then start pulse -> pc_clear=1 for 1 cycle, state=1 next cycle, cycle_cnt=0 then increments to 3 after 3 RUN cycles.
REQ-025 RUN, idex_mem_read=1, idex_rd=5, ifid_rs2=5, ifid_uses_rs2=1 -> 1 cycle with pc_write_en=0, ifid_write_en=0, idex_flush=1; idex_rd=0 -> no stall.
REQ-026 RUN, mem_branch=01, mem_zero=0, simultaneous load_use -> pc_sel=1, pc_write_en=1, all three flushes=1; with mem_branch=11 and mem_jump=0 -> no redirect.
REQ-027 RUN, halt_req -> DRAIN, load_use on the 2nd DRAIN cycle -> HALTED after exactly 5 cycles in DRAIN; cycle_cnt frozen in HALTED.
REQ-028 HALTED, step_req -> one STEP cycle with pc_write_en=1, then 4 DRAIN cycles, then HALTED; start and step_req together -> pc_clear=1, then RUN.
REQ-029 Assert reset asynchronously mid-DRAIN -> state=0 and cycle_cnt=0 before the next clk edge.

Source files
------------

// File: rtl/pipe_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_seq_ctrl_pkg
// Brief    : Shared encodings and helpers for the pipeline sequencer.
// Revision : 1.0
// ============================================================================
package pipe_seq_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam int c_REG_W = 5;

    localparam state_t c_ST_IDLE   = 3'd0;
    localparam state_t c_ST_RUN    = 3'd1;
    localparam state_t c_ST_DRAIN  = 3'd2;
    localparam state_t c_ST_HALTED = 3'd3;
    localparam state_t c_ST_STEP   = 3'd4;

    localparam logic [1:0] c_BR_BEQ  = 2'b00;
    localparam logic [1:0] c_BR_BNE  = 2'b01;
    localparam logic [1:0] c_BR_BLT  = 2'b10;
    localparam logic [1:0] c_BR_NONE = 2'b11;

    localparam logic [2:0] c_DRAIN_DEPTH = 3'd4;

    function automatic logic branch_taken(
        input logic [1:0] br,
        input logic       jump,
        input logic       zero,
        input logic       lt
    );
        return jump
            | ((br == c_BR_BEQ) &  zero)
            | ((br == c_BR_BNE) & ~zero)
            | ((br == c_BR_BLT) &  lt);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_detect
// Brief    : Load-use hazard compare between ID/EX and IF/ID.
// Revision : 1.0
// ============================================================================
module pipe_hazard_detect
    import pipe_seq_ctrl_pkg::*;
(
    input  logic               i_idex_mem_read,
    input  logic [c_REG_W-1:0] i_idex_rd,
    input  logic [c_REG_W-1:0] i_ifid_rs1,
    input  logic [c_REG_W-1:0] i_ifid_rs2,
    input  logic               i_ifid_uses_rs2,
    output logic               o_load_use
);

    // x0 is hard-wired zero, so a load to it never creates a dependency
    assign o_load_use = i_idex_mem_read
                      & (i_idex_rd != '0)
                      & ((i_idex_rd == i_ifid_rs1)
                         | (i_ifid_uses_rs2 & (i_idex_rd == i_ifid_rs2)));

endmodule
`default_nettype wire

// File: rtl/pipe_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_seq_ctrl
// Brief    : Run/halt/step sequencer with branch redirect and load-use stall.
// Revision : 1.0
// ============================================================================
module pipe_seq_ctrl
    import pipe_seq_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         halt_req,
    input  logic         step_req,
    input  logic         idex_mem_read,
    input  logic [4:0]   idex_rd,
    input  logic [4:0]   ifid_rs1,
    input  logic [4:0]   ifid_rs2,
    input  logic         ifid_uses_rs2,
    input  logic [1:0]   mem_branch,
    input  logic         mem_jump,
    input  logic         mem_zero,
    input  logic         mem_lt,
    output logic         pc_write_en,
    output logic         pc_sel,
    output logic         pc_clear,
    output logic         ifid_write_en,
    output logic         ifid_flush,
    output logic         idex_flush,
    output logic         exmem_flush,
    output logic [2:0]   state,
    output logic [31:0]  cycle_cnt
);

    state_t      r_state;
    logic [2:0]  r_drain_cnt;
    logic [31:0] r_cycle_cnt;

    logic w_taken;
    logic w_load_use;
    logic w_stall;
    logic w_active;

    pipe_hazard_detect u_hazard (
        .i_idex_mem_read (idex_mem_read),
        .i_idex_rd       (idex_rd),
        .i_ifid_rs1      (ifid_rs1),
        .i_ifid_rs2      (ifid_rs2),
        .i_ifid_uses_rs2 (ifid_uses_rs2),
        .o_load_use      (w_load_use)
    );

    assign w_taken   = branch_taken(mem_branch, mem_jump, mem_zero, mem_lt);
    assign w_stall   = w_load_use & ~w_taken;
    assign state     = r_state;
    assign cycle_cnt = r_cycle_cnt;

    always_comb begin
        pc_write_en   = 1'b0;
        pc_sel        = 1'b0;
        pc_clear      = 1'b0;
        ifid_write_en = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        w_active      = 1'b0;
        case (r_state)
            c_ST_RUN, c_ST_STEP: begin
                pc_write_en = 1'b1;
                w_active    = 1'b1;
            end
            c_ST_DRAIN: begin
                ifid_flush = 1'b1;
                w_active   = 1'b1;
            end
            c_ST_IDLE, c_ST_HALTED: begin
                pc_clear    = start;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end
            default: begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end
        endcase
        // A redirect squashes the stalled instruction anyway, so it wins
        if (w_active) begin
            if (w_taken) begin
                pc_sel      = 1'b1;
                pc_write_en = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (w_load_use) begin
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
                ifid_flush    = 1'b0;
                idex_flush    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_drain_cnt <= 3'd0;
            r_cycle_cnt <= 32'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state     <= c_ST_RUN;
                        r_cycle_cnt <= 32'd0;
                    end
                end
                c_ST_RUN: begin
                    r_cycle_cnt <= r_cycle_cnt + 32'd1;
                    if (halt_req) begin
                        r_state     <= c_ST_DRAIN;
                        r_drain_cnt <= c_DRAIN_DEPTH;
                    end
                end
                c_ST_DRAIN: begin
                    r_cycle_cnt <= r_cycle_cnt + 32'd1;
                    if (!w_stall) begin
                        if (r_drain_cnt <= 3'd1) begin
                            r_state     <= c_ST_HALTED;
                            r_drain_cnt <= 3'd0;
                        end else begin
                            r_drain_cnt <= r_drain_cnt - 3'd1;
                        end
                    end
                end
                c_ST_HALTED: begin
                    if (start) begin
                        r_state     <= c_ST_RUN;
                        r_cycle_cnt <= 32'd0;
                    end else if (step_req) begin
                        r_state <= c_ST_STEP;
                    end
                end
                c_ST_STEP: begin
                    r_cycle_cnt <= r_cycle_cnt + 32'd1;
                    if (!w_stall) begin
                        r_state     <= c_ST_DRAIN;
                        r_drain_cnt <= c_DRAIN_DEPTH;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
